store_queue: RTL and testbench

- Parametrised successor to the single-port store buffer.
- Circular queue of speculative and committed stores between the execute stage and the dcache write port.
- Stores allocate in program order, commit when the ROB retires them, and drain to dcache via a valid/ack handshake.
- Loads get byte-granular, youngest-first forwarding across all live entries; a flush discards only uncommitted entries.

---
 rtl/sq_pkg.sv | 42 ++++
 rtl/sq_fwd_merge.sv | 54 +++++
 rtl/store_queue.sv | 167 ++++++++++++++++
 tb/tb_store_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// ---------------------------------------------------------------------------
// sq_pkg
//   Shared types, default sizing and pointer helpers for the store queue.
//   The default localparams describe the standard 32-bit / 8-entry build.
//   The helpers take width arguments, so a store_queue instance built with
//   other parameter values can still use them.
//   No ports (package).
// ---------------------------------------------------------------------------
package sq_pkg;

   localparam int SQ_DATA_WIDTH = 32;
   localparam int SQ_ADDR_WIDTH = 32;
   localparam int SQ_DEPTH      = 8;
   localparam int SQ_BE_W       = SQ_DATA_WIDTH / 8;
   localparam int SQ_OFF_W      = $clog2(SQ_BE_W);
   localparam int SQ_PTR_W      = $clog2(SQ_DEPTH) + 1;

   // Entry layout for the default configuration: word address, raw byte
   // enables and lane-aligned data.
   typedef struct packed {
      logic [SQ_ADDR_WIDTH-SQ_OFF_W-1:0] waddr;
      logic [SQ_BE_W-1:0]                be;
      logic [SQ_DATA_WIDTH-1:0]          data;
   } sq_entry_t;

   // The pointer MSB is a wrap bit.
   typedef logic [SQ_PTR_W-1:0] sq_ptr_t;

   // Entry index: the pointer with its wrap bit dropped.
   function automatic logic [31:0] ptr_idx(input logic [31:0] ptr,
                                           input int unsigned idx_w);
      return ptr & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // The queue is full when the pointers differ only in the wrap bit.
   function automatic logic is_full(input logic [31:0] head,
                                    input logic [31:0] tail,
                                    input int unsigned ptr_w);
      return (head ^ tail) == (32'd1 << (ptr_w - 1));
   endfunction

endpackage

// File: rtl/sq_fwd_merge.sv
// ---------------------------------------------------------------------------
// sq_fwd_merge
//   This block is purely combinational. It merges store bytes in age order
//   for one load lookup. Entries are visited from the oldest (head_idx) to
//   the youngest, so a younger matching byte overwrites an older one.
//   Ports:
//     ld_valid, ld_waddr, ld_be : load lookup (word address, needed bytes)
//     live      : one bit per entry, set when the entry holds a store
//     head_idx  : index of the oldest entry
//     ent_waddr, ent_be, ent_data : contents of every entry
//     fwd_mask, fwd_data, fwd_full : merged result; all outputs are 0
//                                    when ld_valid is low
// ---------------------------------------------------------------------------
module sq_fwd_merge #(
   parameter int DEPTH = 8,
   parameter int WA_W  = 30,
   parameter int BE_W  = 4,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                             ld_valid,
   input  logic [WA_W-1:0]                  ld_waddr,
   input  logic [BE_W-1:0]                  ld_be,
   input  logic [DEPTH-1:0]                 live,
   input  logic [IDX_W-1:0]                 head_idx,
   input  logic [DEPTH-1:0][WA_W-1:0]       ent_waddr,
   input  logic [DEPTH-1:0][BE_W-1:0]       ent_be,
   input  logic [DEPTH-1:0][8*BE_W-1:0]     ent_data,
   output logic [BE_W-1:0]                  fwd_mask,
   output logic [8*BE_W-1:0]                fwd_data,
   output logic                             fwd_full
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      idx      = '0;
      fwd_mask = '0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         // The index sum wraps naturally inside IDX_W bits.
         idx = head_idx + IDX_W'(k);
         if (ld_valid && live[idx] && (ent_waddr[idx] == ld_waddr)) begin
            for (int b = 0; b < BE_W; b++) begin
               if (ent_be[idx][b]) begin
                  fwd_mask[b]       = 1'b1;
                  fwd_data[8*b +: 8] = ent_data[idx][8*b +: 8];
               end
            end
         end
      end
   end

   assign fwd_full = ld_valid && (ld_be != '0) && ((fwd_mask & ld_be) == ld_be);

endmodule

// File: rtl/store_queue.sv
// ---------------------------------------------------------------------------
// store_queue
//   This is a circular queue of speculative and committed stores. It sits
//   between the execute stage and the dcache write port.
//   Three pointers keep order, with head <= cmt <= tail (modulo wrap):
//     head : next entry to drain
//     cmt  : first uncommitted entry
//     tail : next entry to allocate
//   Ports:
//     clk_g, reset (synchronous, active-high), flush (drop uncommitted)
//     st_valid/st_ready/st_addr/st_be/st_wdata : allocate a store
//     commit     : retire the oldest uncommitted store
//     ld_valid/ld_addr/ld_be -> fwd_mask/fwd_data/fwd_full : forwarding
//     drain_req/drain_addr/drain_be/drain_data, drain_ack : dcache drain
//     empty, count : occupancy
// ---------------------------------------------------------------------------
module store_queue
   import sq_pkg::*;
#(
   parameter int DATA_WIDTH = SQ_DATA_WIDTH,
   parameter int ADDR_WIDTH = SQ_ADDR_WIDTH,
   parameter int DEPTH      = SQ_DEPTH,
   parameter int PTR_W      = $clog2(DEPTH) + 1
) (
   input  logic                    clk_g,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [ADDR_WIDTH-1:0]   st_addr,
   input  logic [DATA_WIDTH/8-1:0] st_be,
   input  logic [DATA_WIDTH-1:0]   st_wdata,
   input  logic                    commit,
   input  logic                    ld_valid,
   input  logic [ADDR_WIDTH-1:0]   ld_addr,
   input  logic [DATA_WIDTH/8-1:0] ld_be,
   output logic [DATA_WIDTH/8-1:0] fwd_mask,
   output logic [DATA_WIDTH-1:0]   fwd_data,
   output logic                    fwd_full,
   output logic                    drain_req,
   output logic [ADDR_WIDTH-1:0]   drain_addr,
   output logic [DATA_WIDTH/8-1:0] drain_be,
   output logic [DATA_WIDTH-1:0]   drain_data,
   input  logic                    drain_ack,
   output logic                    empty,
   output logic [PTR_W-1:0]        count
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int WA_W  = ADDR_WIDTH - OFF_W;
   localparam int IDX_W = PTR_W - 1;

   typedef struct packed {
      logic [WA_W-1:0]       waddr;
      logic [BE_W-1:0]       be;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t ent_q [DEPTH];
   entry_t ent_d [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] cmt_q,  cmt_d;
   logic [PTR_W-1:0] tail_q, tail_d;

   logic             full;
   logic             alloc;
   logic             do_commit;
   logic             do_drain;
   logic [IDX_W-1:0] head_idx;
   logic [IDX_W-1:0] tail_idx;

   logic [DEPTH-1:0]                 live;
   logic [DEPTH-1:0][WA_W-1:0]       ent_waddr;
   logic [DEPTH-1:0][BE_W-1:0]       ent_be;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

   // The byte-offset address bits are not used for matching or storage.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

   assign head_idx = IDX_W'(ptr_idx(32'(head_q), IDX_W));
   assign tail_idx = IDX_W'(ptr_idx(32'(tail_q), IDX_W));
   assign full     = is_full(32'(head_q), 32'(tail_q), PTR_W);

   assign st_ready  = !full;
   assign count     = tail_q - head_q;
   assign empty     = (head_q == tail_q);
   assign drain_req = (head_q != cmt_q);

   // A flush drops an allocation in the same cycle.
   assign alloc     = st_valid && st_ready && !flush;
   assign do_commit = commit && (cmt_q != tail_q);
   assign do_drain  = drain_req && drain_ack;

   always_comb begin
      head_d = head_q + PTR_W'(do_drain);
      cmt_d  = cmt_q + PTR_W'(do_commit);
      // A flush pulls tail back to the commit boundary. That boundary
      // includes a commit made in the same cycle.
      tail_d = flush ? cmt_d : (tail_q + PTR_W'(alloc));
   end

   always_ff @(posedge clk_g) begin
      if (reset) begin
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         cmt_q  <= cmt_d;
         tail_q <= tail_d;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [IDX_W-1:0] age;

         always_comb begin
            ent_d[gi] = ent_q[gi];
            if (alloc && (tail_idx == IDX_W'(gi))) begin
               ent_d[gi].waddr = st_addr[ADDR_WIDTH-1:OFF_W];
               ent_d[gi].be    = st_be;
               ent_d[gi].data  = st_wdata;
            end
         end

         always_ff @(posedge clk_g) begin
            if (reset) ent_q[gi] <= '0;
            else       ent_q[gi] <= ent_d[gi];
         end

         // An entry is live when its distance from head is less than count.
         assign age           = IDX_W'(gi) - head_idx;
         assign live[gi]      = ({1'b0, age} < count);
         assign ent_waddr[gi] = ent_q[gi].waddr;
         assign ent_be[gi]    = ent_q[gi].be;
         assign ent_data[gi]  = ent_q[gi].data;
      end
   endgenerate

   assign drain_addr = ADDR_WIDTH'(ent_q[head_idx].waddr) << OFF_W;
   assign drain_be   = ent_q[head_idx].be;
   assign drain_data = ent_q[head_idx].data;

   sq_fwd_merge #(
      .DEPTH (DEPTH),
      .WA_W  (WA_W),
      .BE_W  (BE_W),
      .IDX_W (IDX_W)
   ) u_fwd (
      .ld_valid  (ld_valid),
      .ld_waddr  (ld_addr[ADDR_WIDTH-1:OFF_W]),
      .ld_be     (ld_be),
      .live      (live),
      .head_idx  (head_idx),
      .ent_waddr (ent_waddr),
      .ent_be    (ent_be),
      .ent_data  (ent_data),
      .fwd_mask  (fwd_mask),
      .fwd_data  (fwd_data),
      .fwd_full  (fwd_full)
   );

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;

   logic        clk_g = 1'b0;
   logic        reset, flush, st_valid, commit, ld_valid, drain_ack;
   logic [31:0] st_addr, st_wdata, ld_addr;
   logic [3:0]  st_be, ld_be;
   logic        st_ready, fwd_full, drain_req, empty;
   logic [3:0]  fwd_mask, drain_be, count;
   logic [31:0] fwd_data, drain_addr, drain_data;

   int n_vec    = 0;
   int n_err    = 0;
   int tb_uncmt = 0;

   always #5 clk_g = ~clk_g;

   store_queue dut (
      .clk_g(clk_g), .reset(reset), .flush(flush),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_be(st_be), .st_wdata(st_wdata), .commit(commit),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
      .fwd_mask(fwd_mask), .fwd_data(fwd_data), .fwd_full(fwd_full),
      .drain_req(drain_req), .drain_addr(drain_addr), .drain_be(drain_be),
      .drain_data(drain_data), .drain_ack(drain_ack),
      .empty(empty), .count(count)
   );

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus. Inputs are driven 1ns after the edge and cleared afterwards.
   task automatic cyc(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                      input logic [31:0] sd, input logic cm, input logic ack, input logic fl);
      logic acc;
      st_valid = sv; st_addr = sa; st_be = sbe; st_wdata = sd;
      commit = cm; drain_ack = ack; flush = fl;
      #1;
      acc = sv && st_ready && !fl;
      if (cm) assert (tb_uncmt > 0) else $error("commit issued with no uncommitted store");
      $display("cyc t=%0t st=%0b addr=%h be=%h data=%h commit=%0b ack=%0b flush=%0b",
               $time, sv, sa, sbe, sd, cm, ack, fl);
      @(posedge clk_g); #1;
      if (fl) tb_uncmt = 0;
      else    tb_uncmt = tb_uncmt + int'(acc) - int'(cm);
      st_valid = 0; commit = 0; drain_ack = 0; flush = 0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [3:0] be);
      ld_valid = 1'b1; ld_addr = a; ld_be = be;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      reset = 1; flush = 0; st_valid = 0; commit = 0; ld_valid = 0; drain_ack = 0;
      st_addr = 0; st_wdata = 0; ld_addr = 0; st_be = 0; ld_be = 0;
      @(posedge clk_g); @(posedge clk_g); #1;
      reset = 0;

      // Reset state
      ld(32'h0, 4'hF);
      check_vec("rst_ready", st_ready, 1);
      check_vec("rst_empty", empty, 1);
      check_vec("rst_count", count, 0);
      check_vec("rst_dreq",  drain_req, 0);
      check_vec("rst_fmask", fwd_mask, 0);
      check_vec("rst_ffull", fwd_full, 0);

      // Fill until full; a ninth store must be dropped
      for (int i = 0; i < 8; i++) cyc(1, 32'h100 + 4*i, 4'hF, 32'h1000 + i, 0, 0, 0);
      check_vec("full_ready", st_ready, 0);
      check_vec("full_count", count, 8);
      ld(32'h11C, 4'hF);
      check_vec("full_fwd", fwd_data, 32'h1007);
      check_vec("full_ffull", fwd_full, 1);
      cyc(1, 32'h120, 4'hF, 32'hDEAD, 0, 0, 0);
      check_vec("drop_count", count, 8);
      check_vec("dreq_nocmt", drain_req, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         check_vec("fill_dreq",  drain_req, 1);
         check_vec("fill_daddr", drain_addr, 32'h100 + 4*i);
         check_vec("fill_ddata", drain_data, 32'h1000 + i);
         cyc(0, 0, 0, 0, 0, 1, 0);
      end
      check_vec("fill_empty", empty, 1);

      // Byte merge, youngest first
      cyc(1, 32'h200, 4'h1, 32'h000000AA, 0, 0, 0);
      cyc(1, 32'h200, 4'h2, 32'h0000BB00, 0, 0, 0);
      cyc(1, 32'h200, 4'h1, 32'h000000CC, 0, 0, 0);
      ld(32'h200, 4'h3);
      check_vec("merge_data", fwd_data, 32'h0000BBCC);
      check_vec("merge_mask", fwd_mask, 4'h3);
      check_vec("merge_full", fwd_full, 1);
      ld(32'h203, 4'hF);
      check_vec("merge_part", fwd_full, 0);
      check_vec("merge_offs", fwd_data, 32'h0000BBCC);
      ld_valid = 0; #1;
      check_vec("ldoff_mask", fwd_mask, 0);
      check_vec("ldoff_data", fwd_data, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("merge_empty", empty, 1);

      // Flush keeps committed entries; a same-cycle store is dropped
      cyc(1, 32'h300, 4'hF, 32'h0000000A, 0, 0, 0);
      cyc(1, 32'h304, 4'hF, 32'h0000000B, 0, 0, 0);
      cyc(1, 32'h308, 4'hF, 32'h0000000C, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(1, 32'h30C, 4'hF, 32'h0000000D, 1, 0, 1);
      check_vec("flush_count", count, 2);
      ld(32'h308, 4'hF);
      check_vec("flush_C", fwd_mask, 0);
      ld(32'h30C, 4'hF);
      check_vec("flush_D", fwd_mask, 0);
      ld(32'h304, 4'hF);
      check_vec("flush_B", fwd_data, 32'h0000000B);
      ld_valid = 0;
      check_vec("flush_dreqA", drain_req, 1);
      check_vec("flush_addrA", drain_addr, 32'h300);
      check_vec("flush_dataA", drain_data, 32'h0000000A);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("flush_addrB", drain_addr, 32'h304);
      check_vec("flush_dataB", drain_data, 32'h0000000B);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("flush_empty", empty, 1);
      check_vec("flush_dreq0", drain_req, 0);

      // Drain backpressure
      cyc(1, 32'h400, 4'h5, 32'h11223344, 0, 0, 0);
      cyc(1, 32'h404, 4'hA, 32'h55667788, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         check_vec("bp_dreq", drain_req, 1);
         check_vec("bp_addr", drain_addr, 32'h400);
         check_vec("bp_be",   drain_be, 4'h5);
         check_vec("bp_data", drain_data, 32'h11223344);
         cyc(0, 0, 0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("bp_count1", count, 1);
      check_vec("bp_addr2",  drain_addr, 32'h404);
      check_vec("bp_be2",    drain_be, 4'hA);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("bp_empty", empty, 1);

      // Wrap with allocate, commit and ack every cycle
      cyc(1, 32'h500, 4'hF, 32'hD000, 0, 0, 0);
      cyc(1, 32'h504, 4'hF, 32'hD001, 1, 0, 0);
      for (int k = 0; k < 20; k++) begin
         ld(32'h500 + 4*k, 4'hF);
         check_vec("wrap_count", count, 2);
         check_vec("wrap_ddata", drain_data, 32'hD000 + k);
         check_vec("wrap_fwd",   fwd_data, 32'hD000 + k);
         check_vec("wrap_full",  fwd_full, 1);
         cyc(1, 32'h500 + 4*(k+2), 4'hF, 32'hD000 + k + 2, 1, 1, 0);
      end
      ld_valid = 0;
      check_vec("wrap_endcnt", count, 2);
      check_vec("wrap_head",   drain_addr, 32'h550);
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check_vec("wrap_empty", empty, 1);

      // Reset in the middle of draining committed entries
      for (int i = 0; i < 3; i++) cyc(1, 32'h600 + 4*i, 4'hF, 32'h6000 + i, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      reset = 1;
      @(posedge clk_g); #1;
      reset = 0; tb_uncmt = 0;
      ld(32'h604, 4'hF);
      check_vec("mrst_empty", empty, 1);
      check_vec("mrst_dreq",  drain_req, 0);
      check_vec("mrst_fmask", fwd_mask, 0);
      check_vec("mrst_count", count, 0);
      check_vec("mrst_ready", st_ready, 1);
      ld_valid = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
